// File: rtl/ren_binner_pkg.sv
// Shared types for the tile binner: tile classes, FSM states and edge step ops.
// Also derives the edge accumulator width from the coefficient and coordinate widths.
package ren_binner_pkg;

  typedef enum logic [1:0] {
    TC_REJECT  = 2'd0,
    TC_PARTIAL = 2'd1,
    TC_ACCEPT  = 2'd2
  } tile_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } binner_state_e;

  typedef enum logic [1:0] {
    EV_XINC = 2'd0,
    EV_XDEC = 2'd1,
    EV_ROW  = 2'd2,
    EV_YINC = 2'd3
  } edge_step_e;

  // Headroom: coefficient * (tiles * tile size) plus sign and the two corner offsets.
  function automatic int acc_width(input int ef_w, input int coord_w, input int tile_log2);
    return ef_w + coord_w + tile_log2 + 2;
  endfunction

endpackage

// File: rtl/ren_binner_edge_eval.sv
// Incremental evaluator for one edge function over the tile grid.
// Flags a tile as wholly outside (reject) or wholly inside (accept) this edge.
module ren_binner_edge_eval
  import ren_binner_pkg::*;
#(
  parameter int EF_W      = 24,
  parameter int TILE_LOG2 = 4,
  parameter int ACC_W     = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   adv,
  input  edge_step_e             step_op,
  input  logic signed [EF_W-1:0] a,
  input  logic signed [EF_W-1:0] b,
  input  logic signed [EF_W-1:0] c,
  output logic                   reject,
  output logic                   accept
);

  logic signed [ACC_W-1:0] a_ext, b_ext, c_ext;
  logic signed [ACC_W-1:0] dx, dy, row_acc, acc;
  logic signed [ACC_W-1:0] emax, emin;

  function automatic logic signed [ACC_W-1:0] pos_part(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : v;
  endfunction

  function automatic logic signed [ACC_W-1:0] neg_part(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? v : '0;
  endfunction

  assign a_ext = {{(ACC_W-EF_W){a[EF_W-1]}}, a};
  assign b_ext = {{(ACC_W-EF_W){b[EF_W-1]}}, b};
  assign c_ext = {{(ACC_W-EF_W){c[EF_W-1]}}, c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx      <= '0;
      dy      <= '0;
      row_acc <= '0;
      acc     <= '0;
    end else if (load) begin
      dx      <= a_ext <<< TILE_LOG2;
      dy      <= b_ext <<< TILE_LOG2;
      row_acc <= c_ext;
      acc     <= c_ext;
    end else if (adv) begin
      case (step_op)
        EV_XINC: acc <= acc + dx;
        EV_XDEC: acc <= acc - dx;
        EV_ROW: begin
          row_acc <= row_acc + dy;
          acc     <= row_acc + dy;
        end
        default: acc <= acc + dy;
      endcase
    end
  end

  // Linear edge: extremes over the tile lie on the corners picked by the step signs.
  assign emax   = acc + pos_part(dx) + pos_part(dy);
  assign emin   = acc + neg_part(dx) + neg_part(dy);
  assign reject = emax[ACC_W-1];
  assign accept = !emin[ACC_W-1];

endmodule

// File: rtl/ren_binner_fx.sv
// Fixed-point tile binner: walks a primitive's tile bounding box and sorts each
// tile into reject / full-cover (accept FIFO) / partial-cover (raster FIFO).
module ren_binner_fx
  import ren_binner_pkg::*;
#(
  parameter int NUM_EDGES  = 3,
  parameter int EF_W       = 24,
  parameter int COORD_W    = 10,
  parameter int TILE_LOG2  = 4,
  parameter int SERPENTINE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [NUM_EDGES*EF_W-1:0] i_a,
  input  logic [NUM_EDGES*EF_W-1:0] i_b,
  input  logic [NUM_EDGES*EF_W-1:0] i_c,
  input  logic [COORD_W-1:0]        i_min_tx,
  input  logic [COORD_W-1:0]        i_min_ty,
  input  logic [COORD_W-1:0]        i_step_x,
  input  logic [COORD_W-1:0]        i_step_y,
  input  logic                      i_acc_full,
  input  logic                      i_part_full,
  output logic                      o_acc_write,
  output logic                      o_part_write,
  output logic [COORD_W-1:0]        o_tile_x,
  output logic [COORD_W-1:0]        o_tile_y,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*COORD_W-1:0]      o_acc_cnt,
  output logic [2*COORD_W-1:0]      o_part_cnt
);

  localparam int ACC_W = acc_width(EF_W, COORD_W, TILE_LOG2);
  localparam int CNT_W = 2 * COORD_W;

  binner_state_e             state, state_nxt;
  logic [NUM_EDGES*EF_W-1:0] a_q, b_q, c_q;
  logic [COORD_W-1:0]        min_tx_q, min_ty_q, step_x_q, step_y_q;
  logic [COORD_W-1:0]        col_cnt, row_cnt;
  logic [NUM_EDGES-1:0]      rej_v, acc_v;
  tile_class_e               tile_cls;
  edge_step_e                step_op;
  logic                      in_scan, take, can_adv, row_end, last_row, odd_row, load_edges;

  assign in_scan    = (state == ST_SCAN);
  assign o_ready    = (state == ST_IDLE) & i_en;
  assign take       = i_valid & o_ready;
  assign load_edges = (state == ST_SETUP) & i_en;
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE) & i_en;

  always_comb begin
    tile_cls = TC_PARTIAL;
    if (|rej_v)      tile_cls = TC_REJECT;
    else if (&acc_v) tile_cls = TC_ACCEPT;
  end

  assign o_acc_write  = in_scan & (tile_cls == TC_ACCEPT)  & !i_acc_full  & i_en;
  assign o_part_write = in_scan & (tile_cls == TC_PARTIAL) & !i_part_full & i_en;
  // Rejected tiles never wait on a FIFO.
  assign can_adv  = in_scan & i_en & ((tile_cls == TC_REJECT) | o_acc_write | o_part_write);
  assign row_end  = (col_cnt == step_x_q - COORD_W'(1));
  assign last_row = (row_cnt == step_y_q - COORD_W'(1));
  assign odd_row  = (SERPENTINE != 0) && row_cnt[0];

  always_comb begin
    step_op = EV_XINC;
    if (row_end)      step_op = (SERPENTINE != 0) ? EV_YINC : EV_ROW;
    else if (odd_row) step_op = EV_XDEC;
  end

  for (genvar k = 0; k < NUM_EDGES; k++) begin : g_edge
    ren_binner_edge_eval #(
      .EF_W     (EF_W),
      .TILE_LOG2(TILE_LOG2),
      .ACC_W    (ACC_W)
    ) u_eval (
      .clk    (clk),
      .rst    (rst),
      .load   (load_edges),
      .adv    (can_adv),
      .step_op(step_op),
      .a      (a_q[k*EF_W +: EF_W]),
      .b      (b_q[k*EF_W +: EF_W]),
      .c      (c_q[k*EF_W +: EF_W]),
      .reject (rej_v[k]),
      .accept (acc_v[k])
    );
  end

  always_comb begin
    state_nxt = state;
    if (i_en) begin
      case (state)
        ST_IDLE:  if (i_valid) state_nxt = ST_SETUP;
        ST_SETUP: state_nxt = (step_x_q == '0 || step_y_q == '0) ? ST_DONE : ST_SCAN;
        ST_SCAN:  if (can_adv && row_end && last_row) state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Descriptor capture
  always_ff @(posedge clk) begin
    if (take) begin
      a_q      <= i_a;
      b_q      <= i_b;
      c_q      <= i_c;
      min_tx_q <= i_min_tx;
      min_ty_q <= i_min_ty;
      step_x_q <= i_step_x;
      step_y_q <= i_step_y;
    end
  end

  // Tile walk and per-primitive counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tile_x   <= '0;
      o_tile_y   <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      o_acc_cnt  <= '0;
      o_part_cnt <= '0;
    end else begin
      if (take) begin
        o_acc_cnt  <= '0;
        o_part_cnt <= '0;
      end else begin
        if (o_acc_write)  o_acc_cnt  <= o_acc_cnt + CNT_W'(1);
        if (o_part_write) o_part_cnt <= o_part_cnt + CNT_W'(1);
      end
      if (load_edges) begin
        o_tile_x <= min_tx_q;
        o_tile_y <= min_ty_q;
        col_cnt  <= '0;
        row_cnt  <= '0;
      end else if (can_adv && !(row_end && last_row)) begin
        if (row_end) begin
          col_cnt  <= '0;
          row_cnt  <= row_cnt + COORD_W'(1);
          o_tile_y <= o_tile_y + COORD_W'(1);
          if (SERPENTINE == 0) o_tile_x <= min_tx_q;
        end else begin
          col_cnt  <= col_cnt + COORD_W'(1);
          o_tile_x <= odd_row ? o_tile_x - COORD_W'(1) : o_tile_x + COORD_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ren_binner_fx.md
Name: ren_binner_fx

Overview:
Parametrised fixed-point tile binner. It takes NUM_EDGES edge functions E(x,y) = a*x + b*y + c for one primitive and walks the primitive's tile bounding box. Each tile is classified as trivially rejected, fully covered (written to the accept FIFO) or partially covered (written to the raster FIFO). The block sits between primitive setup and the tile FIFOs. Multipliers are replaced by incremental stepping, and an optional serpentine traversal is available.

Parameters:
NUM_EDGES, 3, number of edge functions per primitive (3 = triangle, up to 8 for clipped polygons)
EF_W, 24, signed width of the input a/b/c coefficients
COORD_W, 10, width of tile coordinates and tile step counts
TILE_LOG2, 4, tile size T = 2**TILE_LOG2 pixels
SERPENTINE, 0, traversal order: 0 = row-major raster, 1 = boustrophedon
ACC_W, EF_W+COORD_W+TILE_LOG2+2, internal edge accumulator width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_en  in  1  global enable; when low the FSM, accumulators and counters freeze and both write strobes are 0
i_valid  in  1  primitive descriptor valid
o_ready  out  1  descriptor accepted when i_valid & o_ready
i_a  in  NUM_EDGES*EF_W  packed signed x-coefficients; edge k at [k*EF_W +: EF_W]
i_b  in  NUM_EDGES*EF_W  packed signed y-coefficients
i_c  in  NUM_EDGES*EF_W  E evaluated by upstream at the pixel origin of tile (i_min_tx, i_min_ty)
i_min_tx  in  COORD_W  first tile column
i_min_ty  in  COORD_W  first tile row
i_step_x  in  COORD_W  tile columns to visit
i_step_y  in  COORD_W  tile rows to visit
i_acc_full  in  1  accept FIFO full
i_part_full  in  1  raster FIFO full
o_acc_write  out  1  accept FIFO push (combinational)
o_part_write  out  1  raster FIFO push (combinational)
o_tile_x  out  COORD_W  current tile column
o_tile_y  out  COORD_W  current tile row
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a primitive's scan ends
o_acc_cnt  out  2*COORD_W  accepted tiles for the current primitive
o_part_cnt  out  2*COORD_W  partial tiles for the current primitive

Behaviour:
- Reset, and any assertion of rst mid-scan: state IDLE, o_ready=1, all other outputs 0, counters 0, accumulators 0. No partial write completes.
- FSM states:
  - IDLE: o_ready=1. Handshake → SETUP; the descriptor is registered and counters are cleared.
  - SETUP (1 cycle): sign-extend a, b and c to ACC_W. dx_k = a_k<<TILE_LOG2 and dy_k = b_k<<TILE_LOG2. Row and current accumulators ← c. Tile = (min_tx, min_ty). If step_x==0 or step_y==0 → DONE; otherwise → SCAN.
  - SCAN: classify one tile per cycle (see classification below).
  - DONE: o_done=1 for 1 cycle → IDLE.
- Latency: handshake at cycle 0; the first tile is classified and written in cycle 2.
- Classification, per edge, from the current accumulator e:
  - emax = e + max(dx,0) + max(dy,0)
  - emin = e + min(dx,0) + min(dy,0)
  - Reject if any edge has emax < 0.
  - Else accept if every edge has emin >= 0.
  - Else partial.
  - All comparisons are signed, at full ACC_W, with no saturation.
- Writes and stalls:
  - o_acc_write = SCAN & accept & !i_acc_full & i_en.
  - o_part_write = SCAN & partial & !i_part_full & i_en.
  - If the target FIFO is full, hold the tile, accumulators and counters, and write nothing until full drops.
  - Reject never stalls; the tile advances in the same cycle.
- Advance:
  - Row-major: x+1 with e+=dx. At the last column, x←min_tx, y+1, row accumulator += dy, e ← new row accumulator.
  - Serpentine: even rows step x up (+dx); odd rows step x down (-dx). At the row end, x stays and y+1 with e+=dy.
  - The last tile of the last row → DONE.
- Counters increment on the corresponding write strobe and hold their value until the next handshake.
- Degenerate edge (a=b=0, c<0): every tile rejected and no writes; o_done still pulses.
- i_valid is ignored outside IDLE.

Decomposition:
- ren_binner_pkg: tile_class_e {TC_REJECT, TC_PARTIAL, TC_ACCEPT}, the binner FSM state enum, and a localparam function deriving ACC_W.
- Sub-module ren_binner_edge_eval: one instance per edge via a generate loop. It holds the accumulator, row accumulator, dx and dy, and outputs the reject and accept flags. The top level ANDs/ORs the flags and owns the FSM, coordinates and counters.

Test Plan:
- NUM_EDGES=3, all edges a=b=0 and c=1; min=(0,0), step 2x2; FIFOs never full → 4 accept writes in order (0,0),(1,0),(0,1),(1,1) at cycles 2-5; o_done at cycle 6; o_acc_cnt=4.
- One edge a=-1, b=0, c=24 and the others a=b=0, c=1; step 3x1; T=16 → tile 0 accept, tile 1 partial, tile 2 no write; o_acc_cnt=1, o_part_cnt=1.
- Edge a=b=0, c=-1; step 4x4 → zero writes; o_done pulses 16 cycles after SETUP.
- SERPENTINE=1, all-accept edges, step 3x2 → write order (0,0),(1,0),(2,0),(2,1),(1,1),(0,1).
- All-accept edges with i_acc_full held high for 5 cycles while at tile (1,0) → o_tile stays (1,0) and no write; the write occurs on the cycle full drops; 4 writes total.
- rst pulsed during SCAN of a 4x4 all-accept primitive → next cycle o_busy=0, counters 0, o_ready=1; a fresh primitive then completes normally.
